// File: rtl/can_crc15_check_if.sv
// Receive-bit and result signals between the RX frame controller and the CRC-15 checker.
interface can_crc15_check_if;
  logic        bit_valid;
  logic        rx_bit;
  logic        frame_start;
  logic        abort;
  logic        busy;
  logic        in_crc_field;
  logic        check_done;
  logic        crc_ok;
  logic        crc_err;
  logic        form_err;
  logic [14:0] crc_calc;
  logic [14:0] crc_rx;

  modport master (
    output bit_valid, rx_bit, frame_start, abort,
    input  busy, in_crc_field, check_done, crc_ok, crc_err, form_err, crc_calc, crc_rx
  );

  modport slave (
    input  bit_valid, rx_bit, frame_start, abort,
    output busy, in_crc_field, check_done, crc_ok, crc_err, form_err, crc_calc, crc_rx
  );
endinterface

// File: rtl/can_crc15_check.sv
// CAN 2.0A receive CRC-15 checker: runs the CRC over SOF..data, captures the
// received CRC field and delimiter, and reports match/mismatch/form error.
module can_crc15_check #(
  parameter logic [14:0] POLY           = 15'h4599,
  parameter logic [14:0] CRC_INIT       = 15'h0000,
  parameter int unsigned MAX_DATA_BYTES = 8
) (
  input logic          clk,
  input logic          rst,
  can_crc15_check_if.slave bus
);

  localparam int unsigned DCW = $clog2(8 * MAX_DATA_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CRCF,
    S_DELIM,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [14:0]      crc_q, crc_d;
  logic [14:0]      crc_rx_q, crc_rx_d;
  logic [4:0]       field_cnt_q, field_cnt_d;
  logic [DCW-1:0]   data_cnt_q, data_cnt_d;
  logic             rtr_q, rtr_d;
  logic [2:0]       dlc_q, dlc_d;
  logic             delim_q, delim_d;

  logic             sof;
  logic [3:0]       dlc_full;
  logic [DCW-1:0]   data_bits;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? POLY : '0);
  endfunction

  assign sof      = bus.frame_start & bus.bit_valid;
  // Last DLC bit arrives live at header index 18; the first three are latched.
  assign dlc_full = {dlc_q, bus.rx_bit};
  assign data_bits = rtr_q ? '0 :
                     (32'(dlc_full) > MAX_DATA_BYTES) ? DCW'(8 * MAX_DATA_BYTES) :
                     DCW'({dlc_full, 3'b000});

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_rx_d    = crc_rx_q;
    field_cnt_d = field_cnt_q;
    data_cnt_d  = data_cnt_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    delim_d     = delim_q;

    if (state_q == S_DONE) state_d = S_IDLE;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else if (sof) begin
      state_d     = S_HDR;
      crc_d       = crc_step(CRC_INIT, bus.rx_bit);
      crc_rx_d    = '0;
      field_cnt_d = 5'd1;
      data_cnt_d  = '0;
      rtr_d       = 1'b0;
      dlc_d       = '0;
      delim_d     = 1'b0;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_HDR: begin
          crc_d       = crc_step(crc_q, bus.rx_bit);
          field_cnt_d = field_cnt_q + 5'd1;
          if (field_cnt_q == 5'd12) rtr_d = bus.rx_bit;
          if (field_cnt_q >= 5'd15) dlc_d = {dlc_q[1:0], bus.rx_bit};
          if (field_cnt_q == 5'd18) begin
            field_cnt_d = '0;
            data_cnt_d  = data_bits;
            state_d     = (data_bits != '0) ? S_DATA : S_CRCF;
          end
        end
        S_DATA: begin
          crc_d      = crc_step(crc_q, bus.rx_bit);
          data_cnt_d = data_cnt_q - DCW'(1);
          if (data_cnt_q == DCW'(1)) begin
            field_cnt_d = '0;
            state_d     = S_CRCF;
          end
        end
        S_CRCF: begin
          crc_rx_d    = {crc_rx_q[13:0], bus.rx_bit};
          field_cnt_d = field_cnt_q + 5'd1;
          if (field_cnt_q == 5'd14) state_d = S_DELIM;
        end
        S_DELIM: begin
          delim_d = bus.rx_bit;
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      crc_q       <= CRC_INIT;
      crc_rx_q    <= '0;
      field_cnt_q <= '0;
      data_cnt_q  <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      delim_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_rx_q    <= crc_rx_d;
      field_cnt_q <= field_cnt_d;
      data_cnt_q  <= data_cnt_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      delim_q     <= delim_d;
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.in_crc_field = (state_q == S_CRCF);
  assign bus.check_done   = (state_q == S_DONE);
  assign bus.form_err     = (state_q == S_DONE) & ~delim_q;
  assign bus.crc_ok       = (state_q == S_DONE) & delim_q & (crc_q == crc_rx_q);
  assign bus.crc_err      = (state_q == S_DONE) & delim_q & (crc_q != crc_rx_q);
  assign bus.crc_calc     = crc_q;
  assign bus.crc_rx       = crc_rx_q;

endmodule
